// File: rtl/pwm_capture.sv
// Recovers the duty value of a fixed-period PWM line; value/valid land 2 edges after the closing rise is sampled.
// No backpressure: strobes are single-cycle. Optional 3-tap glitch filter under PWM_CAPTURE_GLITCH_FILTER_EN.
module pwm_capture #(
    parameter int WIDTH   = 8,
    parameter int PERIOD  = 256,
    parameter int TIMEOUT = 512
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             power,
    input  logic             pwmInput,
    output logic [WIDTH-1:0] value,
    output logic             valid,
    output logic             periodError,
    output logic             locked
);
    localparam int PCW = WIDTH + 2;
    localparam int HCW = WIDTH + 1;
    localparam logic [PCW-1:0] PERIOD_C  = PCW'(PERIOD);
    localparam logic [PCW-1:0] TIMEOUT_C = PCW'(TIMEOUT);
    localparam logic [HCW-1:0] HIGH_MAX  = {1'b0, {WIDTH{1'b1}}};

    typedef enum logic {WAIT_EDGE, MEASURE} state_t;

    state_t           state, state_nxt;
    logic [1:0]       sync;
    logic             s, s_prev, rise;
    logic [PCW-1:0]   period_count, period_nxt;
    logic [HCW-1:0]   high_count, high_nxt;
    logic [WIDTH-1:0] value_nxt, high_sat;
    logic             valid_nxt, error_nxt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) sync <= '0;
        else       sync <= {sync[0], pwmInput};
    end

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
    // Majority over the last three synchronized samples kills 1-cycle glitches.
    logic [1:0] hist;
    logic       s_filt;
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hist   <= '0;
            s_filt <= 1'b0;
        end else begin
            hist   <= {hist[0], sync[1]};
            s_filt <= (sync[1] & hist[0]) | (sync[1] & hist[1]) | (hist[0] & hist[1]);
        end
    end
    assign s = s_filt;
`else
    assign s = sync[1];
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) s_prev <= 1'b0;
        else       s_prev <= s;
    end

    assign rise     = s & ~s_prev;
    assign high_sat = (high_count > HIGH_MAX) ? {WIDTH{1'b1}} : high_count[WIDTH-1:0];
    assign locked   = (state == MEASURE);

    always_comb begin
        state_nxt  = state;
        period_nxt = period_count;
        high_nxt   = high_count;
        value_nxt  = value;
        valid_nxt  = 1'b0;
        error_nxt  = 1'b0;
        if (!power) begin
            state_nxt  = WAIT_EDGE;
            period_nxt = '0;
            high_nxt   = '0;
        end else if (rise) begin
            // The first edge after WAIT_EDGE only opens a window.
            if (state == MEASURE) begin
                if (period_count == PERIOD_C) begin
                    value_nxt = high_sat;
                    valid_nxt = 1'b1;
                end else begin
                    error_nxt = 1'b1;
                end
            end
            state_nxt  = MEASURE;
            period_nxt = PCW'(1);
            high_nxt   = HCW'(1);
        end else if (period_count == TIMEOUT_C) begin
            value_nxt  = s ? {WIDTH{1'b1}} : '0;
            valid_nxt  = 1'b1;
            state_nxt  = WAIT_EDGE;
            period_nxt = '0;
            high_nxt   = '0;
        end else begin
            period_nxt = period_count + PCW'(1);
            if (s) high_nxt = high_count + HCW'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= WAIT_EDGE;
            period_count <= '0;
            high_count   <= '0;
            value        <= '0;
            valid        <= 1'b0;
            periodError  <= 1'b0;
        end else begin
            state        <= state_nxt;
            period_count <= period_nxt;
            high_count   <= high_nxt;
            value        <= value_nxt;
            valid        <= valid_nxt;
            periodError  <= error_nxt;
        end
    end
endmodule

// File: tb/tb_pwm_capture.sv
// Randomized PWM streams checked edge by edge against an event-level model of the capture rules.
module tb_pwm_capture;
    localparam int TIMEOUT = 512;
    localparam int PERIOD  = 256;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       power = 1'b1;
    logic       pwmInput = 1'b0;
    logic [7:0] value;
    logic       valid, periodError, locked;

    int n_cmp = 0;
    int n_bad = 0;

    bit       xs[];
    bit       e_vld[], e_err[], e_lock[];
    bit [7:0] e_val[];
    bit [7:0] model_value = 8'd0;
    int       duty_q[$];

    pwm_capture dut (
        .clock(clock), .reset(reset), .power(power), .pwmInput(pwmInput),
        .value(value), .valid(valid), .periodError(periodError), .locked(locked)
    );

    always #5 clock = ~clock;

    function automatic bit x_at(int i);
        if (i < 0 || i >= xs.size()) return 1'b0;
        return xs[i];
    endfunction

    // Level of the conditioned input as seen by the decision logic just before edge j.
    function automatic bit s_at(int j);
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
        int ones;
        ones = int'(x_at(j-3)) + int'(x_at(j-4)) + int'(x_at(j-5));
        return ones >= 2;
`else
        return x_at(j-2);
`endif
    endfunction

    task automatic gen_pwm(input int period);
        xs = new[duty_q.size() * period];
        foreach (duty_q[p])
            for (int t = 0; t < period; t++)
                xs[p*period + t] = (t < duty_q[p]);
    endtask

    task automatic gen_const(input int n, input bit lvl);
        xs = new[n];
        foreach (xs[i]) xs[i] = lvl;
    endtask

    // Events: rising edges open/close windows; a deadline TIMEOUT after the last event forces a level decision.
    task automatic build_model(input int pstart);
        int       n, lock_evt[];
        bit [7:0] ev_val[];
        int       next_to, last_r, ones;
        bit       meas, cur_lock;
        bit [7:0] cur_val;
        n = xs.size();
        e_vld = new[n]; e_err = new[n]; e_lock = new[n]; e_val = new[n];
        lock_evt = new[n]; ev_val = new[n];
        next_to = pstart + TIMEOUT;
        meas = 1'b0;
        last_r = 0;
        for (int r = pstart; r < n; r++) begin
            if (s_at(r) && !s_at(r-1)) begin
                if (meas) begin
                    if (r - last_r == PERIOD) begin
                        ones = 0;
                        for (int j = last_r; j < r; j++) ones += int'(s_at(j));
                        e_vld[r]  = 1'b1;
                        ev_val[r] = (ones > 255) ? 8'd255 : 8'(ones);
                    end else begin
                        e_err[r] = 1'b1;
                    end
                end
                meas = 1'b1;
                last_r = r;
                next_to = r + TIMEOUT;
                lock_evt[r] = 1;
            end else if (r == next_to) begin
                e_vld[r]  = 1'b1;
                ev_val[r] = s_at(r) ? 8'd255 : 8'd0;
                meas = 1'b0;
                next_to = r + TIMEOUT + 1;
                lock_evt[r] = 2;
            end
        end
        cur_val = model_value;
        cur_lock = 1'b0;
        for (int e = 0; e < n; e++) begin
            if (e_vld[e]) cur_val = ev_val[e];
            if (lock_evt[e] == 1) cur_lock = 1'b1;
            else if (lock_evt[e] == 2) cur_lock = 1'b0;
            e_val[e]  = cur_val;
            e_lock[e] = cur_lock;
        end
        model_value = cur_val;
    endtask

    // Drives xs one sample per edge (power low before pstart) and checks every output after each edge.
    task automatic run_stream(input string name, input int pstart);
        build_model(pstart);
        for (int i = 0; i < xs.size(); i++) begin
            power = (i >= pstart);
            pwmInput = xs[i];
            @(posedge clock);
            @(negedge clock);
            n_cmp += 4;
            if (valid !== e_vld[i]) begin
                n_bad++;
                $display("FAIL %s valid edge %0d: got %b expected %b", name, i, valid, e_vld[i]);
            end
            if (periodError !== e_err[i]) begin
                n_bad++;
                $display("FAIL %s periodError edge %0d: got %b expected %b", name, i, periodError, e_err[i]);
            end
            if (value !== e_val[i]) begin
                n_bad++;
                $display("FAIL %s value edge %0d: got %0d expected %0d", name, i, value, e_val[i]);
            end
            if (locked !== e_lock[i]) begin
                n_bad++;
                $display("FAIL %s locked edge %0d: got %b expected %b", name, i, locked, e_lock[i]);
            end
        end
        power = 1'b1;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        power = 1'b1;
        pwmInput = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        model_value = 8'd0;
    endtask

    task automatic check_idle(input string name);
        n_cmp += 4;
        if (value !== 8'd0)      begin n_bad++; $display("FAIL %s value: got %0d expected 0", name, value); end
        if (valid !== 1'b0)      begin n_bad++; $display("FAIL %s valid: got %b expected 0", name, valid); end
        if (periodError !== 1'b0) begin n_bad++; $display("FAIL %s periodError: got %b expected 0", name, periodError); end
        if (locked !== 1'b0)     begin n_bad++; $display("FAIL %s locked: got %b expected 0", name, locked); end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clock);
        check_idle("reset_hold");
        reset = 1'b0;
        @(negedge clock);
        check_idle("reset_release");
    endtask

    task automatic test_loop_duty100();
        do_reset();
        duty_q = '{100, 100, 100};
        gen_pwm(PERIOD);
        run_stream("duty100", 0);
    endtask

    task automatic test_sweep();
        duty_q = '{};
        foreach (duty_q[i]) duty_q.delete(i);
        for (int i = 0; i < 12; i++) begin
            int d;
            case (i)
                0: d = 1;   1: d = 2;   2: d = 127;
                3: d = 128; 4: d = 254; 5: d = 255;
                default: d = $urandom_range(1, 255);
            endcase
            duty_q.push_back(d);
            duty_q.push_back(d);
        end
        gen_pwm(PERIOD);
        run_stream("sweep", 8);
    endtask

    task automatic test_const_low();
        gen_const(1100, 1'b0);
        run_stream("const_low", 8);
    endtask

    task automatic test_const_high();
        gen_const(1200, 1'b1);
        run_stream("const_high", 8);
    endtask

    task automatic test_period_error();
        duty_q = '{50, 50, 50, 50, 50, 50};
        gen_pwm(250);
        run_stream("period250", 8);
    endtask

    task automatic test_reset_mid();
        do_reset();
        xs = new[2*PERIOD + 130];
        foreach (xs[i]) xs[i] = ((i % PERIOD) < 200);
        run_stream("mid_pre", 0);
        #2 reset = 1'b1;
        #1 check_idle("mid_reset_async");
        @(negedge clock);
        reset = 1'b0;
        model_value = 8'd0;
        xs = new[(PERIOD - 130) + 3*PERIOD];
        foreach (xs[i]) xs[i] = (((130 + i) % PERIOD) < 200);
        run_stream("mid_post", 0);
    endtask

    task automatic test_power();
        int d;
        d = $urandom_range(20, 230);
        xs = new[300 + 3*PERIOD];
        foreach (xs[i]) xs[i] = ((i % PERIOD) < d);
        run_stream("power", 300);
    endtask

    task automatic test_glitch();
        duty_q = '{100, 100, 100, 100};
        gen_pwm(PERIOD);
        xs[PERIOD + 50] = 1'b0;
        run_stream("glitch", 8);
    endtask

    initial begin
        test_reset();
        test_loop_duty100();
        test_sweep();
        test_const_low();
        test_const_high();
        test_period_error();
        test_reset_mid();
        test_power();
        test_glitch();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
